// File: rtl/aq_biu_read_arb.sv
// Read-channel arbiter for the BIU: shares one AR port between I-fetch refill (req 0)
// and load/store (req 1), tracks outstanding reads and routes R beats back, registered.
module aq_biu_read_arb #(
   parameter int MAX_OUTSTD = 4
) (
   input  logic         biu_clk,
   input  logic         cpurst_b,

   input  logic         req0_arvalid,
   output logic         req0_arready,
   input  logic [39:0]  req0_araddr,
   input  logic [2:0]   req0_arid,
   input  logic [1:0]   req0_arlen,
   input  logic [2:0]   req0_arsize,
   input  logic [1:0]   req0_arburst,
   input  logic [3:0]   req0_arcache,
   input  logic [2:0]   req0_arprot,
   input  logic         req0_arlock,
   output logic         req0_rvalid,
   output logic [127:0] req0_rdata,
   output logic [2:0]   req0_rid,
   output logic [1:0]   req0_rresp,
   output logic         req0_rlast,

   input  logic         req1_arvalid,
   output logic         req1_arready,
   input  logic [39:0]  req1_araddr,
   input  logic [2:0]   req1_arid,
   input  logic [1:0]   req1_arlen,
   input  logic [2:0]   req1_arsize,
   input  logic [1:0]   req1_arburst,
   input  logic [3:0]   req1_arcache,
   input  logic [2:0]   req1_arprot,
   input  logic         req1_arlock,
   output logic         req1_rvalid,
   output logic [127:0] req1_rdata,
   output logic [2:0]   req1_rid,
   output logic [1:0]   req1_rresp,
   output logic         req1_rlast,

   output logic         arvalid,
   input  logic         arready,
   output logic [39:0]  araddr,
   output logic [3:0]   arid,
   output logic [1:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic [3:0]   arcache,
   output logic [2:0]   arprot,
   output logic         arlock,

   input  logic         rvalid,
   input  logic [127:0] rdata,
   input  logic [3:0]   rid,
   input  logic [1:0]   rresp,
   input  logic         rlast,

   output logic         arb_err
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTD);

   logic       rr_ptr;
   logic       hold;
   logic       hold_idx;
   logic [2:0] cnt_0;
   logic [2:0] cnt_1;

   logic       elig_0;
   logic       elig_1;
   logic       elig_prio;
   logic       elig_alt;
   logic       grant_vld;
   logic       grant_idx;
   logic       ar_hs;
   logic       inc_0;
   logic       inc_1;
   logic       dec_0;
   logic       dec_1;

   // Handshake: a transfer happens when valid and ready are both high at the clock
   // edge; once valid is raised, valid and payload stay unchanged until that edge.
   always_comb begin
      elig_0    = req0_arvalid & (cnt_0 < MAX_CNT);
      elig_1    = req1_arvalid & (cnt_1 < MAX_CNT);
      elig_prio = rr_ptr ? elig_1 : elig_0;
      elig_alt  = rr_ptr ? elig_0 : elig_1;
      grant_vld = 1'b0;
      grant_idx = rr_ptr;
      if (hold) begin
         grant_vld = 1'b1;
         grant_idx = hold_idx;
      end else if (elig_prio) begin
         grant_vld = 1'b1;
         grant_idx = rr_ptr;
      end else if (elig_alt) begin
         grant_vld = 1'b1;
         grant_idx = ~rr_ptr;
      end
   end

   always_comb begin
      if (grant_idx) begin
         araddr  = req1_araddr;
         arid    = {1'b1, req1_arid};
         arlen   = req1_arlen;
         arsize  = req1_arsize;
         arburst = req1_arburst;
         arcache = req1_arcache;
         arprot  = req1_arprot;
         arlock  = req1_arlock;
      end else begin
         araddr  = req0_araddr;
         arid    = {1'b0, req0_arid};
         arlen   = req0_arlen;
         arsize  = req0_arsize;
         arburst = req0_arburst;
         arcache = req0_arcache;
         arprot  = req0_arprot;
         arlock  = req0_arlock;
      end
   end

   assign arvalid      = grant_vld;
   assign ar_hs        = grant_vld & arready;
   assign req0_arready = ar_hs & ~grant_idx;
   assign req1_arready = ar_hs & grant_idx;

   assign inc_0 = req0_arready;
   assign inc_1 = req1_arready;
   assign dec_0 = rvalid & rlast & ~rid[3];
   assign dec_1 = rvalid & rlast & rid[3];

   // A stalled grant is pinned so the presented request cannot change under backpressure.
   always_ff @(posedge biu_clk) begin
      if (!cpurst_b) begin
         rr_ptr   <= 1'b0;
         hold     <= 1'b0;
         hold_idx <= 1'b0;
      end else begin
         hold <= grant_vld & ~arready;
         if (grant_vld & ~arready)
            hold_idx <= grant_idx;
         if (ar_hs)
            rr_ptr <= ~grant_idx;
      end
   end

   always_ff @(posedge biu_clk) begin
      if (!cpurst_b) begin
         cnt_0   <= 3'd0;
         cnt_1   <= 3'd0;
         arb_err <= 1'b0;
      end else begin
         if (inc_0 & ~dec_0)
            cnt_0 <= cnt_0 + 3'd1;
         else if (dec_0 & ~inc_0 & (cnt_0 != 3'd0))
            cnt_0 <= cnt_0 - 3'd1;
         if (inc_1 & ~dec_1)
            cnt_1 <= cnt_1 + 3'd1;
         else if (dec_1 & ~inc_1 & (cnt_1 != 3'd0))
            cnt_1 <= cnt_1 - 3'd1;
         // A final beat with nothing outstanding means the ID routing is broken.
         if ((dec_0 & (cnt_0 == 3'd0)) | (dec_1 & (cnt_1 == 3'd0)))
            arb_err <= 1'b1;
      end
   end

   always_ff @(posedge biu_clk) begin
      if (!cpurst_b) begin
         req0_rvalid <= 1'b0;
         req0_rdata  <= '0;
         req0_rid    <= 3'd0;
         req0_rresp  <= 2'd0;
         req0_rlast  <= 1'b0;
         req1_rvalid <= 1'b0;
         req1_rdata  <= '0;
         req1_rid    <= 3'd0;
         req1_rresp  <= 2'd0;
         req1_rlast  <= 1'b0;
      end else begin
         req0_rvalid <= rvalid & ~rid[3];
         req1_rvalid <= rvalid & rid[3];
         if (rvalid & ~rid[3]) begin
            req0_rdata <= rdata;
            req0_rid   <= rid[2:0];
            req0_rresp <= rresp;
            req0_rlast <= rlast;
         end
         if (rvalid & rid[3]) begin
            req1_rdata <= rdata;
            req1_rid   <= rid[2:0];
            req1_rresp <= rresp;
            req1_rlast <= rlast;
         end
      end
   end

endmodule

// File: tb/tb_aq_biu_read_arb.sv
// Self-checking bench for aq_biu_read_arb: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration, counting and routing.
module tb_aq_biu_read_arb;

   logic         biu_clk = 1'b0;
   logic         cpurst_b;
   logic         req0_arvalid, req0_arready, req0_arlock;
   logic [39:0]  req0_araddr;
   logic [2:0]   req0_arid, req0_arsize, req0_arprot;
   logic [1:0]   req0_arlen, req0_arburst;
   logic [3:0]   req0_arcache;
   logic         req0_rvalid, req0_rlast;
   logic [127:0] req0_rdata;
   logic [2:0]   req0_rid;
   logic [1:0]   req0_rresp;
   logic         req1_arvalid, req1_arready, req1_arlock;
   logic [39:0]  req1_araddr;
   logic [2:0]   req1_arid, req1_arsize, req1_arprot;
   logic [1:0]   req1_arlen, req1_arburst;
   logic [3:0]   req1_arcache;
   logic         req1_rvalid, req1_rlast;
   logic [127:0] req1_rdata;
   logic [2:0]   req1_rid;
   logic [1:0]   req1_rresp;
   logic         arvalid, arready, arlock;
   logic [39:0]  araddr;
   logic [3:0]   arid, arcache;
   logic [1:0]   arlen, arburst;
   logic [2:0]   arsize, arprot;
   logic         rvalid, rlast;
   logic [127:0] rdata;
   logic [3:0]   rid;
   logic [1:0]   rresp;
   logic         arb_err;

   int checks = 0;
   int errors = 0;

   // stimulus state per requester
   bit           pend[2];
   logic [39:0]  m_addr[2];
   logic [2:0]   m_id[2];
   logic [14:0]  m_attr[2];

   logic [134:0] exp_q[$];

   aq_biu_read_arb #(.MAX_OUTSTD(4)) dut (
      .biu_clk(biu_clk), .cpurst_b(cpurst_b),
      .req0_arvalid(req0_arvalid), .req0_arready(req0_arready), .req0_araddr(req0_araddr),
      .req0_arid(req0_arid), .req0_arlen(req0_arlen), .req0_arsize(req0_arsize),
      .req0_arburst(req0_arburst), .req0_arcache(req0_arcache), .req0_arprot(req0_arprot),
      .req0_arlock(req0_arlock), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
      .req0_rid(req0_rid), .req0_rresp(req0_rresp), .req0_rlast(req0_rlast),
      .req1_arvalid(req1_arvalid), .req1_arready(req1_arready), .req1_araddr(req1_araddr),
      .req1_arid(req1_arid), .req1_arlen(req1_arlen), .req1_arsize(req1_arsize),
      .req1_arburst(req1_arburst), .req1_arcache(req1_arcache), .req1_arprot(req1_arprot),
      .req1_arlock(req1_arlock), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
      .req1_rid(req1_rid), .req1_rresp(req1_rresp), .req1_rlast(req1_rlast),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arcache(arcache), .arprot(arprot), .arlock(arlock),
      .rvalid(rvalid), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
      .arb_err(arb_err)
   );

   // clock / reset
   always #5 biu_clk = ~biu_clk;

   task automatic tick();
      @(posedge biu_clk);
      #1;
   endtask

   // drivers
   task automatic apply_req();
      req0_arvalid = pend[0];
      req0_araddr  = m_addr[0];
      req0_arid    = m_id[0];
      {req0_arlen, req0_arsize, req0_arburst, req0_arcache, req0_arprot, req0_arlock} = m_attr[0];
      req1_arvalid = pend[1];
      req1_araddr  = m_addr[1];
      req1_arid    = m_id[1];
      {req1_arlen, req1_arsize, req1_arburst, req1_arcache, req1_arprot, req1_arlock} = m_attr[1];
   endtask

   task automatic set_beat(input logic v, input logic [3:0] id, input logic [127:0] d,
                           input logic [1:0] resp, input logic last);
      rvalid = v;
      rid    = id;
      rdata  = d;
      rresp  = resp;
      rlast  = last;
   endtask

   task automatic set_idle();
      for (int n = 0; n < 2; n++) begin
         pend[n]   = 1'b0;
         m_addr[n] = '0;
         m_id[n]   = '0;
         m_attr[n] = '0;
      end
      apply_req();
      arready = 1'b0;
      set_beat(1'b0, 4'h0, '0, 2'b00, 1'b0);
   endtask

   task automatic do_reset();
      set_idle();
      cpurst_b = 1'b0;
      tick();
      tick();
      cpurst_b = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      set_idle();
      cpurst_b = 1'b0;
      set_beat(1'b1, 4'h9, 128'hdead, 2'b11, 1'b1);
      tick();
      set_beat(1'b0, 4'h0, '0, 2'b00, 1'b0);
      tick();
      checks++;
      if ({req0_rvalid, req1_rvalid, arb_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b want 000", {req0_rvalid, req1_rvalid, arb_err});
      end
      checks++;
      if ({req0_rdata, req0_rid, req0_rresp, req0_rlast, req1_rdata, req1_rid, req1_rresp, req1_rlast} !== '0) begin
         errors++;
         $display("FAIL reset_rdata got r0=%h r1=%h want 0", req0_rdata, req1_rdata);
      end
      checks++;
      if (arvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_arvalid got %b want 0", arvalid);
      end
      pend[1] = 1'b1;
      m_id[1] = 3'd6;
      apply_req();
      #1;
      checks++;
      if ({arvalid, arid} !== 5'b1_1110) begin
         errors++;
         $display("FAIL reset_comb_grant got %b_%h want 1_e", arvalid, arid);
      end
      cpurst_b = 1'b1;
      set_idle();
      tick();
   endtask

   task automatic test_single();
      do_reset();
      pend[0]   = 1'b1;
      m_addr[0] = 40'h00_8000_0040;
      m_id[0]   = 3'd5;
      apply_req();
      arready = 1'b1;
      #1;
      checks++;
      if ({arvalid, arid, araddr, req0_arready, req1_arready} !== {1'b1, 4'h5, 40'h00_8000_0040, 2'b10}) begin
         errors++;
         $display("FAIL single_req got v=%b id=%h a=%h rdy=%b%b want 1 5 0080000040 10",
                  arvalid, arid, araddr, req0_arready, req1_arready);
      end
      tick();
      pend[0] = 1'b0;
      apply_req();
      checks++;
      if (dut.cnt_0 !== 3'd1) begin
         errors++;
         $display("FAIL single_cnt0 got %0d want 1", dut.cnt_0);
      end
   endtask

   task automatic test_round_robin();
      logic want;
      do_reset();
      pend[0] = 1'b1;
      pend[1] = 1'b1;
      m_id[0] = 3'd1;
      m_id[1] = 3'd2;
      apply_req();
      arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         want = 1'(i % 2);
         #1;
         checks++;
         if ({arvalid, arid[3], req0_arready, req1_arready} !== {1'b1, want, ~want, want}) begin
            errors++;
            $display("FAIL rr_grant_%0d got v=%b g=%b rdy=%b%b want g=%b", i, arvalid, arid[3],
                     req0_arready, req1_arready, want);
         end
         tick();
      end
      set_idle();
      #1;
   endtask

   task automatic test_backpressure();
      do_reset();
      pend[0]   = 1'b1;
      m_addr[0] = 40'h11_0000_0100;
      m_id[0]   = 3'd1;
      arready   = 1'b1;
      apply_req();
      tick();
      // req1 now has priority; req0 presents a new request that stalls
      m_addr[0] = 40'h22_0000_0200;
      m_id[0]   = 3'd3;
      m_attr[0] = 15'h5a5a;
      arready   = 1'b0;
      apply_req();
      #1;
      checks++;
      if ({arvalid, arid} !== 5'b1_0011) begin
         errors++;
         $display("FAIL bp_first got %b_%h want 1_3", arvalid, arid);
      end
      tick();
      pend[1]   = 1'b1;
      m_addr[1] = 40'h33_0000_0300;
      m_id[1]   = 3'd7;
      apply_req();
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, req0_arready, req1_arready}
             !== {1'b1, 4'h3, 40'h22_0000_0200, 15'h5a5a, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold_%0d got v=%b id=%h a=%h want 1 3 2200000200", i, arvalid, arid, araddr);
         end
         tick();
      end
      arready = 1'b1;
      #1;
      checks++;
      if ({req0_arready, req1_arready, arid} !== {2'b10, 4'h3}) begin
         errors++;
         $display("FAIL bp_release got rdy=%b%b id=%h want 10 3", req0_arready, req1_arready, arid);
      end
      tick();
      pend[0] = 1'b0;
      apply_req();
      #1;
      checks++;
      if ({arvalid, arid, req1_arready} !== {1'b1, 4'hf, 1'b1}) begin
         errors++;
         $display("FAIL bp_next_req1 got v=%b id=%h rdy1=%b want 1 f 1", arvalid, arid, req1_arready);
      end
      tick();
      set_idle();
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      arready = 1'b1;
      pend[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_id[1] = 3'(i);
         apply_req();
         #1;
         checks++;
         if (req1_arready !== 1'b1) begin
            errors++;
            $display("FAIL lim_fill_%0d got rdy1=%b want 1", i, req1_arready);
         end
         tick();
      end
      m_id[1] = 3'd4;
      apply_req();
      #1;
      checks++;
      if ({arvalid, req1_arready} !== 2'b00) begin
         errors++;
         $display("FAIL lim_blocked got v=%b rdy1=%b want 00", arvalid, req1_arready);
      end
      pend[0] = 1'b1;
      m_id[0] = 3'd2;
      apply_req();
      #1;
      checks++;
      if ({arvalid, arid, req0_arready, req1_arready} !== {1'b1, 4'h2, 2'b10}) begin
         errors++;
         $display("FAIL lim_req0_pass got v=%b id=%h rdy=%b%b want 1 2 10", arvalid, arid,
                  req0_arready, req1_arready);
      end
      tick();
      pend[0] = 1'b0;
      apply_req();
      set_beat(1'b1, 4'h9, 128'h77, 2'b00, 1'b1);
      #1;
      checks++;
      if (arvalid !== 1'b0) begin
         errors++;
         $display("FAIL lim_still_full got v=%b want 0", arvalid);
      end
      tick();
      set_beat(1'b0, 4'h0, '0, 2'b00, 1'b0);
      #1;
      checks++;
      if ({dut.cnt_1, arvalid, arid, req1_arready} !== {3'd3, 1'b1, 4'hc, 1'b1}) begin
         errors++;
         $display("FAIL lim_reopen got cnt=%0d v=%b id=%h rdy1=%b want 3 1 c 1", dut.cnt_1, arvalid,
                  arid, req1_arready);
      end
      tick();
      set_idle();
   endtask

   task automatic test_response_routing();
      do_reset();
      pend[1] = 1'b1;
      arready = 1'b1;
      apply_req();
      tick();
      pend[1] = 1'b0;
      apply_req();
      set_beat(1'b1, 4'hA, 128'h1234, 2'b10, 1'b1);
      tick();
      set_beat(1'b0, 4'h0, '0, 2'b00, 1'b0);
      checks++;
      if ({req1_rvalid, req1_rid, req1_rresp, req1_rlast, req1_rdata, req0_rvalid}
          !== {1'b1, 3'd2, 2'b10, 1'b1, 128'h1234, 1'b0}) begin
         errors++;
         $display("FAIL route_beat got v1=%b id=%0d resp=%b d=%h v0=%b want 1 2 10 1234 0",
                  req1_rvalid, req1_rid, req1_rresp, req1_rdata, req0_rvalid);
      end
      tick();
      checks++;
      if ({req1_rvalid, req1_rdata} !== {1'b0, 128'h1234}) begin
         errors++;
         $display("FAIL route_pulse_hold got v1=%b d=%h want 0 1234", req1_rvalid, req1_rdata);
      end
   endtask

   task automatic test_random();
      int mo[2];
      int mprio;
      int mlock;
      int g;
      int n;
      logic [134:0] e;
      do_reset();
      mo[0] = 0;
      mo[1] = 0;
      mprio = 0;
      mlock = -1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         // scoreboard: last cycle's beat must show up now on its owner only
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (e[134] == 1'b0) begin
               if ({req0_rvalid, req1_rvalid, req0_rid, req0_rresp, req0_rlast, req0_rdata} !== {2'b10, e[133:0]}) begin
                  errors++;
                  $display("FAIL rnd_route0 cyc=%0d got v=%b%b id=%0d d=%h want id=%0d d=%h", cyc,
                           req0_rvalid, req1_rvalid, req0_rid, req0_rdata, e[133:131], e[127:0]);
               end
            end else begin
               if ({req0_rvalid, req1_rvalid, req1_rid, req1_rresp, req1_rlast, req1_rdata} !== {2'b01, e[133:0]}) begin
                  errors++;
                  $display("FAIL rnd_route1 cyc=%0d got v=%b%b id=%0d d=%h want id=%0d d=%h", cyc,
                           req0_rvalid, req1_rvalid, req1_rid, req1_rdata, e[133:131], e[127:0]);
               end
            end
         end else begin
            checks++;
            if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
               errors++;
               $display("FAIL rnd_quiet cyc=%0d got v=%b%b want 00", cyc, req0_rvalid, req1_rvalid);
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 2) != 0) begin
               pend[r]   = 1'b1;
               m_addr[r] = {8'($urandom), 32'($urandom)};
               m_id[r]   = 3'($urandom);
               m_attr[r] = 15'($urandom);
            end
         end
         apply_req();
         arready = ($urandom_range(0, 3) != 0);
         n = -1;
         if ($urandom_range(0, 1) == 1) begin
            if (mo[0] > 0 && mo[1] > 0) n = int'($urandom_range(0, 1));
            else if (mo[0] > 0) n = 0;
            else if (mo[1] > 0) n = 1;
         end
         if (n >= 0)
            set_beat(1'b1, {1'(n), 3'($urandom)}, {$urandom, $urandom, $urandom, $urandom},
                     2'($urandom), 1'($urandom_range(0, 1)));
         else
            set_beat(1'b0, 4'h0, '0, 2'b00, 1'b0);
         #1;
         // reference grant: a stalled request keeps the port, else priority then the other
         g = -1;
         if (mlock >= 0) g = mlock;
         else if (pend[mprio] && mo[mprio] < 4) g = mprio;
         else if (pend[1 - mprio] && mo[1 - mprio] < 4) g = 1 - mprio;
         checks++;
         if (g < 0) begin
            if ({arvalid, req0_arready, req1_arready} !== 3'b000) begin
               errors++;
               $display("FAIL rnd_nogrant cyc=%0d got v=%b rdy=%b%b want 000", cyc, arvalid,
                        req0_arready, req1_arready);
            end
         end else begin
            if ({arvalid, arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, req0_arready, req1_arready}
                !== {1'b1, 1'(g), m_id[g], m_addr[g], m_attr[g], arready && g == 0, arready && g == 1}) begin
               errors++;
               $display("FAIL rnd_grant cyc=%0d got v=%b id=%h a=%h rdy=%b%b want g=%0d id=%h a=%h", cyc,
                        arvalid, arid, araddr, req0_arready, req1_arready, g, m_id[g], m_addr[g]);
            end
         end
         if (g >= 0 && arready) begin
            mo[g]++;
            pend[g] = 1'b0;
            mprio   = 1 - g;
            mlock   = -1;
         end else if (g >= 0) begin
            mlock = g;
         end
         if (rvalid) begin
            exp_q.push_back({rid[3], rid[2:0], rresp, rlast, rdata});
            if (rlast) mo[rid[3]]--;
         end
         tick();
      end
      checks++;
      if ({arb_err, dut.cnt_0, dut.cnt_1} !== {1'b0, 3'(mo[0]), 3'(mo[1])}) begin
         errors++;
         $display("FAIL rnd_counts got err=%b c0=%0d c1=%0d want 0 %0d %0d", arb_err, dut.cnt_0,
                  dut.cnt_1, mo[0], mo[1]);
      end
      set_idle();
      tick();
   endtask

   task automatic test_spurious();
      do_reset();
      checks++;
      if (arb_err !== 1'b0) begin
         errors++;
         $display("FAIL spur_pre got %b want 0", arb_err);
      end
      set_beat(1'b1, 4'h1, 128'h55, 2'b00, 1'b1);
      tick();
      set_beat(1'b0, 4'h0, '0, 2'b00, 1'b0);
      checks++;
      if ({arb_err, dut.cnt_0} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL spur_flag got err=%b cnt0=%0d want 1 0", arb_err, dut.cnt_0);
      end
      tick();
      tick();
      tick();
      checks++;
      if (arb_err !== 1'b1) begin
         errors++;
         $display("FAIL spur_sticky got %b want 1", arb_err);
      end
   endtask

   initial begin
      set_idle();
      cpurst_b = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_outstanding_limit();
      test_response_routing();
      test_random();
      test_spurious();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
